// File: rtl/syzygy_adc_pkg.sv
// Shared types and helpers for the triggered ADC snapshot buffer.
// Holds the capture FSM state encoding and the signed level-crossing test.
package syzygy_adc_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } state_e;

    // p is the previous valid sample and s the current one, both two's-complement.
    function automatic logic trig_cross(
        input logic signed [DATA_W_DEF-1:0] p,
        input logic signed [DATA_W_DEF-1:0] s,
        input logic signed [DATA_W_DEF-1:0] level,
        input logic                         rising
    );
        if (rising) return (p < level) && (s >= level);
        else        return (p > level) && (s <= level);
    endfunction

endpackage

// File: rtl/syzygy_adc_capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port
// with 1-cycle latency and a synchronous reset on the output register.
module syzygy_adc_capture_ram #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset)      rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/syzygy_adc_capture.sv
// Triggered snapshot buffer for two ADC channels: arm, trigger, capture, drain.
// Optional per-capture decimation is enabled by defining SYZYGY_ADC_CAPTURE_DECIM_EN.
module syzygy_adc_capture
    import syzygy_adc_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     adc_data_1,
    input  logic [DATA_W-1:0]     adc_data_2,
    input  logic                  data_valid,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trig_ch,
    input  logic                  trig_rising,
    input  logic                  trig_force,
    input  logic [DATA_W-1:0]     trig_level,
    input  logic [DATA_W-1:0]     sample_count,
`ifdef SYZYGY_ADC_CAPTURE_DECIM_EN
    input  logic [7:0]            decim,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [DEPTH_LOG2:0]   words_left,
    input  logic                  rd_en,
    output logic [2*DATA_W-1:0]   rd_data,
    output logic                  rd_valid,
    output state_e                fsm_state
);

    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE  = (DEPTH_LOG2+1)'(1);

    state_e                state, state_next;
    logic [DEPTH_LOG2:0]   target, target_in;
    logic [DEPTH_LOG2:0]   wr_count;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DATA_W-1:0]     prev_sample, sel_sample;
    logic                  prev_valid, trig_hit, keep, wr_en, wr_last, rd_fire;

    // Zero and oversize requests both mean "fill the whole buffer".
    always_comb begin
        target_in = (DEPTH_LOG2+1)'(sample_count);
        if (sample_count == '0 || 32'(sample_count) > 32'(FULL)) target_in = FULL;
    end

    assign sel_sample = trig_ch ? adc_data_2 : adc_data_1;
    assign trig_hit   = data_valid && (trig_force ||
                        (prev_valid && trig_cross(prev_sample, sel_sample, trig_level, trig_rising)));

`ifdef SYZYGY_ADC_CAPTURE_DECIM_EN
    logic [7:0] decim_cnt;
    assign keep = (decim_cnt == decim);

    // Restarting on the trigger guarantees the trigger sample is kept.
    always_ff @(posedge clk) begin
        if (reset || abort)                     decim_cnt <= '0;
        else if (state == ARMED && wr_en)       decim_cnt <= '0;
        else if (state == CAPTURE && data_valid) decim_cnt <= keep ? 8'd0 : decim_cnt + 8'd1;
    end
`else
    assign keep = 1'b1;
`endif

    assign wr_en   = !abort && ((state == ARMED && trig_hit) ||
                                (state == CAPTURE && data_valid && keep));
    assign wr_last = (wr_count + ONE) == target;
    assign rd_fire = !abort && state == READOUT && rd_en && words_left != '0;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arm) state_next = ARMED;
            ARMED:   if (wr_en) state_next = wr_last ? READOUT : CAPTURE;
            CAPTURE: if (wr_en && wr_last) state_next = READOUT;
            READOUT: if (rd_fire && words_left == ONE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_comb begin
        busy      = (state == ARMED) || (state == CAPTURE);
        done      = (state == READOUT);
        fsm_state = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target      <= '0;
            wr_count    <= '0;
            rd_ptr      <= '0;
            words_left  <= '0;
            rd_valid    <= 1'b0;
            prev_sample <= '0;
            prev_valid  <= 1'b0;
        end else if (abort) begin
            wr_count   <= '0;
            rd_ptr     <= '0;
            words_left <= '0;
            rd_valid   <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (state == IDLE && arm) begin
                target     <= target_in;
                wr_count   <= '0;
                rd_ptr     <= '0;
                prev_valid <= 1'b0;
            end
            if (state == ARMED && data_valid) begin
                prev_sample <= sel_sample;
                prev_valid  <= 1'b1;
            end
            if (wr_en) begin
                wr_count <= wr_count + ONE;
                if (wr_last) words_left <= target;
            end
            if (rd_fire) begin
                rd_ptr     <= rd_ptr + DEPTH_LOG2'(1);
                words_left <= words_left - ONE;
            end
        end
    end

    syzygy_adc_capture_ram #(
        .ADDR_W (DEPTH_LOG2),
        .WORD_W (2*DATA_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_count[DEPTH_LOG2-1:0]),
        .wr_data ({adc_data_2, adc_data_1}),
        .rd_en   (rd_fire),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule
